// File: rtl/obstacle_scroll_engine.sv
// obstacle_scroll_engine
// Scrolls N_OBS ground obstacles left once per frame, ramps scroll speed over
// time, renders a per-pixel obstacle mask + sprite ROM address, detects
// pixel-exact dino/obstacle collisions and runs the IDLE/RUN/OVER game FSM.
//
// Ports
//   clk, reset     system clock, async active-high reset
//   i_pix_en       1-cycle pixel strobe; pixel path advances only on it
//   i_frame_end    1-cycle pulse between frames; drives scrolling/score
//   i_start        start button level (rising edge detected here)
//   i_x, i_y       current pixel column / row
//   i_dino_px      dino opaque, aligned with o_obs_on/o_obs_addr
//   i_obs_px       sprite ROM data for o_obs_addr (1 clk after the address)
//   o_obs_on       registered: pixel inside any obstacle box
//   o_obs_addr     registered: row*OBS_W+col inside winning box, 0 if none
//   o_state        00 IDLE, 01 RUN, 10 OVER
//   o_game_over    state == OVER
//   o_score        frames survived in current run, saturating
//   o_speed        current scroll speed, pixels/frame
module obstacle_scroll_engine #(
  parameter int N_OBS       = 3,
  parameter int OBS_W       = 49,
  parameter int OBS_H       = 80,
  parameter int GROUND      = 335,
  parameter int SCREEN_W    = 640,
  parameter int SPACING     = 200,
  parameter int SPEED_INIT  = 1,
  parameter int SPEED_MAX   = 8,
  parameter int STEP_FRAMES = 256,
  parameter int SCORE_W     = 16,
  parameter int ADDR_W      = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_pix_en,
  input  logic               i_frame_end,
  input  logic               i_start,
  input  logic [9:0]         i_x,
  input  logic [8:0]         i_y,
  input  logic               i_dino_px,
  input  logic               i_obs_px,
  output logic               o_obs_on,
  output logic [ADDR_W-1:0]  o_obs_addr,
  output logic [1:0]         o_state,
  output logic               o_game_over,
  output logic [SCORE_W-1:0] o_score,
  output logic [3:0]         o_speed
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_OVER = 2'b10
  } state_t;

  localparam int         CNT_W = $clog2(STEP_FRAMES + 1);
  localparam logic [8:0] TOP_Y = 9'(GROUND - OBS_H);
  localparam logic [8:0] BOT_Y = 9'(GROUND);

  state_t             r_state, w_next;
  logic               r_start_q;
  logic [7:0]         r_lfsr;
  logic [10:0]        r_obs_x  [N_OBS];
  logic [10:0]        w_obs_nx [N_OBS];
  logic [N_OBS-1:0]   w_resp;
  logic [SCORE_W-1:0] r_score;
  logic [3:0]         r_speed;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               r_obs_on;
  logic [ADDR_W-1:0]  r_obs_addr;

  logic               w_start_rise, w_collide, w_run_entry, w_frame_step;
  logic [N_OBS-1:0]   w_hit;
  logic               w_y_in;
  logic [10:0]        w_win_x;
  logic [8:0]         w_row;
  logic [10:0]        w_col;
  logic [ADDR_W-1:0]  w_addr;
  logic [11:0]        w_far, w_cand;

  assign w_start_rise = i_start & ~r_start_q;
  // r_obs_on/i_obs_px/i_dino_px all refer to the pixel registered last strobe
  assign w_collide    = r_obs_on & i_obs_px & i_dino_px & (r_state == S_RUN);
  assign w_run_entry  = (r_state != S_RUN) && (w_next == S_RUN);
  // a collision in the same cycle freezes the world instead of scrolling it
  assign w_frame_step = (r_state == S_RUN) && i_frame_end && !w_collide;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_rise) w_next = S_RUN;
      S_RUN:   if (w_collide)    w_next = S_OVER;
      S_OVER:  if (w_start_rise) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- per-frame motion ----------------
  // Survivors move first and set the far edge; respawners are then placed
  // behind it in index order, each one becoming the new far edge.
  always_comb begin
    w_far  = '0;
    w_cand = '0;
    w_resp = '0;
    for (int i = 0; i < N_OBS; i++) begin
      w_resp[i]   = r_obs_x[i] < {7'b0, r_speed};
      w_obs_nx[i] = r_obs_x[i] - {7'b0, r_speed};
      if (!w_resp[i] && ({1'b0, w_obs_nx[i]} > w_far))
        w_far = {1'b0, w_obs_nx[i]};
    end
    for (int i = 0; i < N_OBS; i++) begin
      if (w_resp[i]) begin
        w_cand = w_far + 12'(SPACING) + {6'b0, r_lfsr[5:0]};
        if (w_cand < 12'(SCREEN_W)) w_cand = 12'(SCREEN_W);
        w_obs_nx[i] = w_cand[10:0];
        w_far       = w_cand;
      end
    end
  end

  assign w_cnt_inc = r_cnt + 1'b1;

  // ---------------- pixel hit test ----------------
  assign w_y_in = (i_y >= TOP_Y) && (i_y < BOT_Y);

  genvar g;
  generate
    for (g = 0; g < N_OBS; g++) begin : g_hit
      assign w_hit[g] = w_y_in && ({1'b0, i_x} >= r_obs_x[g]) &&
                        ({2'b0, i_x} < ({1'b0, r_obs_x[g]} + 12'(OBS_W)));
    end
  endgenerate

  // lowest index wins: scan downward so the last assignment is the lowest hit
  always_comb begin
    w_win_x = '0;
    for (int i = N_OBS - 1; i >= 0; i--)
      if (w_hit[i]) w_win_x = r_obs_x[i];
  end

  assign w_row  = i_y - TOP_Y;
  assign w_col  = {1'b0, i_x} - w_win_x;
  assign w_addr = ADDR_W'(w_row) * ADDR_W'(OBS_W) + ADDR_W'(w_col);

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start_q  <= 1'b0;
      r_lfsr     <= 8'hA5;
      r_score    <= '0;
      r_speed    <= 4'(SPEED_INIT);
      r_cnt      <= '0;
      r_obs_on   <= 1'b0;
      r_obs_addr <= '0;
      for (int i = 0; i < N_OBS; i++)
        r_obs_x[i] <= 11'(SCREEN_W + i * SPACING);
    end else begin
      r_start_q <= i_start;
      if (w_run_entry) begin
        r_score <= '0;
        r_speed <= 4'(SPEED_INIT);
        r_cnt   <= '0;
        for (int i = 0; i < N_OBS; i++)
          r_obs_x[i] <= 11'(SCREEN_W + i * SPACING);
      end else if (w_frame_step) begin
        for (int i = 0; i < N_OBS; i++)
          r_obs_x[i] <= w_obs_nx[i];
        if (~&r_score) r_score <= r_score + 1'b1;
        if (w_cnt_inc == CNT_W'(STEP_FRAMES)) begin
          r_cnt <= '0;
          if (r_speed < 4'(SPEED_MAX)) r_speed <= r_speed + 1'b1;
        end else begin
          r_cnt <= w_cnt_inc;
        end
        // x^8+x^6+x^5+x^4+1
        r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      end
      if (i_pix_en) begin
        r_obs_on   <= |w_hit;
        r_obs_addr <= (|w_hit) ? w_addr : '0;
      end
    end
  end

  assign o_obs_on    = r_obs_on;
  assign o_obs_addr  = r_obs_addr;
  assign o_state     = r_state;
  assign o_game_over = (r_state == S_OVER);
  assign o_score     = r_score;
  assign o_speed     = r_speed;

endmodule
